// File: rtl/score_pkg.sv
// Shared types and constants for the score BCD display: FSM states, glyph
// defaults, sprite index base, and an elaboration-time power-of-ten helper.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam int GLYPH_W_DEF = 12;
  localparam int GLYPH_H_DEF = 12;

  // Digit sprites occupy ROM slots SPR_DIGIT_0 .. SPR_DIGIT_0+9.
  localparam logic [3:0] SPR_DIGIT_0 = 4'd0;
  localparam logic [3:0] SPR_NONE    = 4'd0;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bcd_double_dabble.sv
// Iterative binary-to-BCD converter: one shift-and-add-3 step per clock,
// SCORE_W steps per conversion. o_done flags the final step.
module bcd_double_dabble #(
  parameter int SCORE_W    = 20,
  parameter int NUM_DIGITS = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_start,
  input  logic [SCORE_W-1:0]      i_value,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] r_shift;
  logic [BW-1:0]      r_bcd;
  logic [CW-1:0]      r_cnt;
  logic               r_run;
  logic [BW-1:0]      w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (r_bcd[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
  end

  assign o_done = r_run && (r_cnt == CW'(SCORE_W - 1));
  assign o_bcd  = r_bcd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b0;
    end else if (i_start) begin
      r_shift <= i_value;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_run   <= 1'b1;
    end else if (r_run) begin
      r_bcd   <= {w_adj[BW-2:0], r_shift[SCORE_W-1]};
      r_shift <= {r_shift[SCORE_W-2:0], 1'b0};
      r_cnt   <= r_cnt + CW'(1);
      if (o_done) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/score_bcd_display.sv
// Score / high-score digit display: load FSM around the BCD converter,
// high-score tracking, and the DrawX/DrawY digit-cell decoder.
module score_bcd_display
  import score_pkg::*;
#(
  parameter int SCORE_W    = 20,
  parameter int NUM_DIGITS = 6,
  parameter int GLYPH_W    = GLYPH_W_DEF,
  parameter int GLYPH_H    = GLYPH_H_DEF,
  parameter int SCORE_X    = 72,
  parameter int HI_X       = 216,
  parameter int ROW_Y      = 54,
  parameter int BLANK_LZ   = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_load,
  input  logic               hiscore_clear,
  output logic               busy,
  output logic [SCORE_W-1:0] hiscore,
  output logic               is_digit,
  output logic [3:0]         digit_sprite,
  output logic               digit_row
);

  localparam int          BW  = 4 * NUM_DIGITS;
  localparam logic [63:0] LIM = pow10(NUM_DIGITS) - 64'd1;

  state_t             r_state, w_next;
  logic               w_start, w_done;
  logic [SCORE_W-1:0] w_start_val, w_clamped;
  logic               r_pend;
  logic [SCORE_W-1:0] r_pend_val, r_operand, r_hiscore;
  logic [BW-1:0]      r_score_bcd, r_hi_bcd, w_bcd;

  assign w_clamped = (64'(score) > LIM) ? LIM[SCORE_W-1:0] : score;

  bcd_double_dabble #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_dd (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_start (w_start),
    .i_value (w_start_val),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );

  // A load arriving in COMMIT is newer than anything pending, so it wins.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_start_val = w_clamped;
    case (r_state)
      IDLE: if (score_load) begin
        w_start = 1'b1;
        w_next  = CONVERT;
      end
      CONVERT: if (w_done) w_next = COMMIT;
      COMMIT: begin
        if (score_load) begin
          w_start = 1'b1;
          w_next  = CONVERT;
        end else if (r_pend) begin
          w_start     = 1'b1;
          w_start_val = r_pend_val;
          w_next      = CONVERT;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      r_operand  <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) r_operand <= w_start_val;
      if (r_state == COMMIT) begin
        r_pend <= 1'b0;
      end else if (r_state == CONVERT && score_load) begin
        r_pend     <= 1'b1;
        r_pend_val <= w_clamped;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_score_bcd <= '0;
      r_hi_bcd    <= '0;
      r_hiscore   <= '0;
    end else begin
      if (r_state == COMMIT) r_score_bcd <= w_bcd;
      if (hiscore_clear) begin
        r_hiscore <= '0;
        r_hi_bcd  <= '0;
      end else if (r_state == COMMIT && r_operand > r_hiscore) begin
        r_hiscore <= r_operand;
        r_hi_bcd  <= w_bcd;
      end
    end
  end

  assign busy    = (r_state != IDLE);
  assign hiscore = r_hiscore;

  // Per-cell draw mask: a cell is lit once any digit at or above it is nonzero.
  logic [NUM_DIGITS-1:0] w_sc_lit, w_hi_lit;
  always_comb begin
    logic sc_on, hi_on;
    sc_on    = (BLANK_LZ == 0);
    hi_on    = (BLANK_LZ == 0);
    w_sc_lit = '0;
    w_hi_lit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sc_on = sc_on | (r_score_bcd[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) | (i == NUM_DIGITS-1);
      hi_on = hi_on | (r_hi_bcd[4*(NUM_DIGITS-1-i) +: 4] != 4'd0) | (i == NUM_DIGITS-1);
      w_sc_lit[i] = sc_on;
      w_hi_lit[i] = hi_on;
    end
  end

  logic [31:0] w_x, w_y;
  logic        w_yin;
  assign w_x   = 32'(DrawX);
  assign w_y   = 32'(DrawY);
  assign w_yin = (w_y >= 32'(ROW_Y)) && (w_y < 32'(ROW_Y + GLYPH_H));

  always_comb begin
    is_digit     = 1'b0;
    digit_sprite = SPR_NONE;
    digit_row    = 1'b0;
    if (w_yin) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_x >= 32'(SCORE_X + i*GLYPH_W) && w_x < 32'(SCORE_X + (i+1)*GLYPH_W)) begin
          is_digit     = w_sc_lit[i];
          digit_sprite = SPR_DIGIT_0 + r_score_bcd[4*(NUM_DIGITS-1-i) +: 4];
          digit_row    = 1'b0;
        end else if (w_x >= 32'(HI_X + i*GLYPH_W) && w_x < 32'(HI_X + (i+1)*GLYPH_W)) begin
          is_digit     = w_hi_lit[i];
          digit_sprite = SPR_DIGIT_0 + r_hi_bcd[4*(NUM_DIGITS-1-i) +: 4];
          digit_row    = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_score_bcd_display.sv
// Directed plus random bench for score_bcd_display; expected digits come from
// decimal arithmetic on the loaded values.
`timescale 1ns/1ps
module tb_score_bcd_display;

  localparam int SW = 20;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [9:0]    DrawX, DrawY;
  logic [SW-1:0] score;
  logic          score_load, hiscore_clear;
  logic          busy;
  logic [SW-1:0] hiscore;
  logic          is_digit;
  logic [3:0]    digit_sprite;
  logic          digit_row;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_hi   = 0;

  always #50 Clk = ~Clk;

  score_bcd_display dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .score         (score),
    .score_load    (score_load),
    .hiscore_clear (hiscore_clear),
    .busy          (busy),
    .hiscore       (hiscore),
    .is_digit      (is_digit),
    .digit_sprite  (digit_sprite),
    .digit_row     (digit_row)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    n_assert++;
    assert (obs === 32'(expv)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clampv(input int s);
    return (s > 999999) ? 999999 : s;
  endfunction

  function automatic int p10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p *= 10;
    return p;
  endfunction

  // Cell i (0 = leftmost) shows decimal digit 10^(5-i); blank above the leading digit.
  task automatic check_row(input int row, input int v, input string tag);
    for (int i = 0; i < 6; i++) begin
      for (int e = 0; e < 2; e++) begin
        DrawX = 10'(((row != 0) ? 216 : 72) + i*12 + e*11);
        DrawY = 10'(54 + $urandom_range(0, 11));
        #1;
        if (i == 5 || v >= p10(5 - i)) begin
          chk($sformatf("%s c%0d is_digit", tag, i), 32'(is_digit), 1);
          chk($sformatf("%s c%0d sprite", tag, i), 32'(digit_sprite), (v / p10(5 - i)) % 10);
          chk($sformatf("%s c%0d row", tag, i), 32'(digit_row), row);
        end else begin
          chk($sformatf("%s c%0d blank", tag, i), 32'(is_digit), 0);
        end
      end
    end
  endtask

  task automatic check_outside();
    int xs[6] = '{71, 144, 100, 100, 215, 288};
    int ys[6] = '{60, 60, 53, 66, 60, 60};
    for (int k = 0; k < 6; k++) begin
      DrawX = 10'(xs[k]);
      DrawY = 10'(ys[k]);
      #1;
      chk($sformatf("out%0d is_digit", k), 32'(is_digit), 0);
      chk($sformatf("out%0d sprite", k), 32'(digit_sprite), 0);
      chk($sformatf("out%0d row", k), 32'(digit_row), 0);
    end
  endtask

  task automatic load(input int v);
    score      = SW'(v);
    score_load = 1'b1;
    tick();
    score_load = 1'b0;
  endtask

  task automatic wait_conv(output int nb);
    nb = 0;
    while (busy && nb < 200) begin
      nb++;
      tick();
    end
  endtask

  task automatic do_conv(input int v, input string tag);
    int nb, cv;
    load(v);
    wait_conv(nb);
    chk({tag, " busy cycles"}, 32'(nb), 21);
    cv = clampv(v);
    if (cv > exp_hi) exp_hi = cv;
    chk({tag, " hiscore"}, 32'(hiscore), exp_hi);
    check_row(0, cv, {tag, " score"});
    check_row(1, exp_hi, {tag, " hi"});
  endtask

  initial begin
    int nb, v;
    Reset = 1'b1; score = '0; score_load = 1'b0; hiscore_clear = 1'b0;
    DrawX = '0; DrawY = '0;
    #10;
    chk("reset busy", 32'(busy), 0);
    chk("reset hiscore", 32'(hiscore), 0);
    check_row(0, 0, "reset score");
    check_row(1, 0, "reset hi");
    tick(); tick();
    Reset = 1'b0;
    tick();
    chk("idle busy", 32'(busy), 0);
    check_outside();

    do_conv(1230, "1230");
    do_conv(1048575, "clamp");

    hiscore_clear = 1'b1; tick(); hiscore_clear = 1'b0;
    chk("clear idle hiscore", 32'(hiscore), 0);
    exp_hi = 0;
    check_row(1, 0, "clear idle hi");
    check_row(0, 999999, "clear idle score");

    do_conv(500, "500");
    do_conv(300, "300");

    // 100 in flight; 42 then 77 arrive while busy, only 77 survives.
    load(100);
    nb = 0;
    for (int s = 1; s <= 80; s++) begin
      if (!busy) break;
      nb++;
      if (s == 22) begin
        DrawX = 10'(72 + 3*12 + 5); DrawY = 10'd60; #1;
        chk("pend first commit c3", 32'(digit_sprite), 1);
        chk("pend first commit c3 drawn", 32'(is_digit), 1);
        DrawX = 10'(72 + 2*12 + 5); #1;
        chk("pend first commit c2 blank", 32'(is_digit), 0);
        chk("pend hiscore kept", 32'(hiscore), 500);
      end
      score_load = (s == 4 || s == 8);
      score      = (s == 4) ? SW'(42) : SW'(77);
      tick();
      score_load = 1'b0;
    end
    chk("pend busy cycles", 32'(nb), 42);
    chk("pend hiscore", 32'(hiscore), exp_hi);
    check_row(0, 77, "pend score");
    check_row(1, exp_hi, "pend hi");

    // Clear coinciding with the COMMIT of 900.
    hiscore_clear = 1'b1; tick(); hiscore_clear = 1'b0;
    exp_hi = 0;
    load(900);
    for (int s = 1; s < 21; s++) tick();
    chk("commit cycle busy", 32'(busy), 1);
    hiscore_clear = 1'b1; tick(); hiscore_clear = 1'b0;
    chk("clr@commit busy", 32'(busy), 0);
    chk("clr@commit hiscore", 32'(hiscore), 0);
    check_row(0, 900, "clr@commit score");
    check_row(1, 0, "clr@commit hi");

    for (int r = 0; r < 8; r++) begin
      v = (r % 2 == 0) ? int'($urandom_range(0, 20'hFFFFF)) : int'($urandom_range(0, 9999));
      do_conv(v, $sformatf("rnd%0d", r));
    end

    // Reset in the middle of a conversion.
    load(555);
    for (int s = 0; s < 5; s++) tick();
    Reset = 1'b1; #1;
    chk("midreset busy", 32'(busy), 0);
    chk("midreset hiscore", 32'(hiscore), 0);
    exp_hi = 0;
    check_row(0, 0, "midreset score");
    check_row(1, 0, "midreset hi");
    tick();
    Reset = 1'b0;
    tick();
    do_conv(4321, "post reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
